// File: rtl/dir_key_debouncer_pkg.sv
// Shared definitions for the direction-key debouncer: FSM encoding and default debounce length.
package dir_key_debouncer_pkg;

  // 20 ms at the 50 MHz board clock
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } dk_state_t;

endpackage

// File: rtl/dir_key_debouncer_if.sv
// Key-side signal bundle: raw active-low button in, debounced level/strobe/direction out.
interface dir_key_if;
  logic key_n;
  logic up_down;
  logic press_pulse;
  logic key_state;

  modport master (output key_n, input up_down, press_pulse, key_state);
  modport slave  (input key_n, output up_down, press_pulse, key_state);
endinterface

// File: rtl/dir_key_debouncer_sync_2ff.sv
// Two-flop synchronizer for one asynchronous board input; 2-cycle latency, reset to RESET_VAL.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic FPGA_clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge FPGA_clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dir_key_debouncer.sv
// Debounces an active-low pushbutton; one press_pulse and an up_down toggle per accepted press.
// Press latency is DEBOUNCE_CYCLES + 3 edges from the first low sample of key_n.
module dir_key_debouncer
  import dir_key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit          INIT_UP         = 1'b1
) (
  input  logic      FPGA_clock,
  input  logic      reset,
  dir_key_if.slave  bus
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

  logic          key_p;
  logic          k_s;
  dk_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic          pulse_q, pulse_nx;
  logic          up_q, up_nx;
  logic          ks_q, ks_nx;

  assign key_p = ~bus.key_n;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync (
    .FPGA_clock (FPGA_clock),
    .reset      (reset),
    .d          (key_p),
    .q          (k_s)
  );

  always_ff @(posedge FPGA_clock or negedge reset) begin
    if (!reset) begin
      state   <= RELEASED;
      cnt     <= '0;
      pulse_q <= 1'b0;
      up_q    <= INIT_UP;
      ks_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pulse_q <= pulse_nx;
      up_q    <= up_nx;
      ks_q    <= ks_nx;
    end
  end

  // Counter only holds a value while checking; any opposite sample restarts it from zero.
  always_comb begin
    cnt_inc  = (cnt == CNT_DONE) ? cnt : cnt + CW'(1);
    state_nx = state;
    cnt_nx   = '0;
    pulse_nx = 1'b0;
    up_nx    = up_q;
    ks_nx    = ks_q;
    case (state)
      RELEASED: begin
        if (k_s) state_nx = PRESS_CHK;
      end
      PRESS_CHK: begin
        if (!k_s) begin
          state_nx = RELEASED;
        end else if (cnt_inc == CNT_DONE) begin
          state_nx = PRESSED;
          pulse_nx = 1'b1;
          up_nx    = ~up_q;
          ks_nx    = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      PRESSED: begin
        if (!k_s) state_nx = RELEASE_CHK;
      end
      RELEASE_CHK: begin
        if (k_s) begin
          state_nx = PRESSED;
        end else if (cnt_inc == CNT_DONE) begin
          state_nx = RELEASED;
          ks_nx    = 1'b0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: state_nx = RELEASED;
    endcase
  end

  // up_down feeds the downstream up/down counter directly.
  assign bus.up_down     = up_q;
  assign bus.press_pulse = pulse_q;
  assign bus.key_state   = ks_q;

endmodule
